// File: rtl/gpio_in_sampler_if.sv
// rtl/gpio_in_sampler_if.sv - pad-side, enable and interrupt signal bundle for gpio_in_sampler
interface gpio_in_sampler_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] gpio_pins_in;
  logic             EN_PWM_OUTA0;
  logic             EN_PWM_OUTB0;
  logic             EN_TMR_IN0;
  logic             EN_I2C;
  logic             EN_SPI;
  logic             EN_UART;
  logic [WIDTH-1:0] irq_rise_en;
  logic [WIDTH-1:0] irq_fall_en;
  logic [WIDTH-1:0] irq_clr;
  logic [WIDTH-1:0] gpio_data_out;
  logic [WIDTH-1:0] irq_pending;
  logic             irq;
  logic             tmr_in0;

  modport master (
    output gpio_pins_in, EN_PWM_OUTA0, EN_PWM_OUTB0, EN_TMR_IN0, EN_I2C, EN_SPI, EN_UART,
    output irq_rise_en, irq_fall_en, irq_clr,
    input  gpio_data_out, irq_pending, irq, tmr_in0
  );

  modport slave (
    input  gpio_pins_in, EN_PWM_OUTA0, EN_PWM_OUTB0, EN_TMR_IN0, EN_I2C, EN_SPI, EN_UART,
    input  irq_rise_en, irq_fall_en, irq_clr,
    output gpio_data_out, irq_pending, irq, tmr_in0
  );
endinterface

// File: rtl/gpio_in_sampler.sv
// rtl/gpio_in_sampler.sv - GPIO input synchroniser, debouncer, function mask and edge interrupts
module gpio_in_sampler #(
  parameter int WIDTH      = 16,
  parameter int DEB_CYCLES = 4
) (
  input logic               clk,
  input logic               rst_n,
  gpio_in_sampler_if.slave  bus
);

  localparam int            CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] stable_dly_q;
  logic [WIDTH-1:0] pend_q;
  logic [WIDTH-1:0] pend_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic             irq_q;
  logic             tmr_q;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  // Same pin map as the output mux; pins 15:11 are always plain GPIO.
  always_comb begin
    mask       = '0;
    mask[1:0]  = {2{bus.EN_UART}};
    mask[3:2]  = {2{bus.EN_I2C}};
    mask[7:4]  = {4{bus.EN_SPI}};
    mask[8]    = bus.EN_TMR_IN0;
    mask[9]    = bus.EN_PWM_OUTA0;
    mask[10]   = bus.EN_PWM_OUTB0;
  end

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  assign rise = stable_q & ~stable_dly_q;
  assign fall = ~stable_q & stable_dly_q;

  // A new edge event wins over a same-cycle clear; ownership by a function wins over both.
  assign pend_d = ~mask & (((rise & bus.irq_rise_en) | (fall & bus.irq_fall_en)) |
                           (pend_q & ~bus.irq_clr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      pend_q       <= '0;
      irq_q        <= 1'b0;
      tmr_q        <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q      <= bus.gpio_pins_in;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      pend_q       <= pend_d;
      irq_q        <= |pend_d;
      // Timer capture bypasses the debouncer to keep its edge timing.
      tmr_q        <= sync2_q[8] & bus.EN_TMR_IN0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.gpio_data_out = stable_q & ~mask;
  assign bus.irq_pending   = pend_q;
  assign bus.irq           = irq_q;
  assign bus.tmr_in0       = tmr_q;

endmodule
